agc_peak_ctrl: RTL

AGC_PEAK_CTRL -- requirements
Module: agc_peak_ctrl

---
 rtl/agc_peak_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/agc_peak_ctrl.sv
// Peak-detecting AGC loop controller: measures a window peak, then requests gain up/down until in range.
// Optional AGC_CLIP_FAST_EN: a full-scale valid sample ends the measurement window immediately.
module agc_peak_ctrl #(
  parameter int DATA_W     = 8,
  parameter int WIN_LEN    = 64,
  parameter int SETTLE_CYC = 16,
  parameter int HI_TH      = 100,
  parameter int LO_TH      = 40
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              enable,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample,
  input  logic              search_done,
  output logic              adjust,
  output logic              up_dn,
  output logic              locked,
  output logic [DATA_W-2:0] peak_out
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MEASURE = 3'd1,
    DECIDE  = 3'd2,
    ADJUST  = 3'd3,
    SETTLE  = 3'd4,
    LOCKED  = 3'd5
  } state_t;

  localparam logic [15:0]       WIN_LAST    = 16'(WIN_LEN - 1);
  localparam logic [15:0]       SETTLE_LAST = 16'(SETTLE_CYC - 1);
  localparam logic [DATA_W-2:0] HI_V        = (DATA_W-1)'(HI_TH);
  localparam logic [DATA_W-2:0] LO_V        = (DATA_W-1)'(LO_TH);

  state_t            r_state;
  logic [DATA_W-2:0] r_peak;
  logic [15:0]       r_win_cnt;
  logic [15:0]       r_settle_cnt;
  logic              r_adjust;
  logic              r_up_dn;
  logic              r_locked;
  logic [DATA_W-2:0] r_peak_out;

  logic [DATA_W-1:0] w_neg;
  logic [DATA_W-2:0] w_mag;
  logic [DATA_W-2:0] w_peak_new;
  logic              w_win_end;

  // Magnitude saturates so the most negative code maps to full scale
  always_comb begin
    w_neg = ~sample + 1'b1;
    if (!sample[DATA_W-1])
      w_mag = sample[DATA_W-2:0];
    else if (sample[DATA_W-2:0] == '0)
      w_mag = '1;
    else
      w_mag = w_neg[DATA_W-2:0];
    w_peak_new = (w_mag > r_peak) ? w_mag : r_peak;
`ifdef AGC_CLIP_FAST_EN
    w_win_end = (r_win_cnt == WIN_LAST) || (w_mag == '1);
`else
    w_win_end = (r_win_cnt == WIN_LAST);
`endif
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      r_state      <= IDLE;
      r_peak       <= '0;
      r_win_cnt    <= '0;
      r_settle_cnt <= '0;
      r_adjust     <= 1'b0;
      r_up_dn      <= 1'b0;
      r_locked     <= 1'b0;
      r_peak_out   <= '0;
    end else begin
      r_adjust <= 1'b0;
      r_locked <= 1'b0;
      if (!enable) begin
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            r_state   <= MEASURE;
            r_peak    <= '0;
            r_win_cnt <= '0;
          end
          MEASURE: begin
            if (sample_valid) begin
              r_peak    <= w_peak_new;
              r_win_cnt <= r_win_cnt + 16'd1;
              if (w_win_end) begin
                r_state    <= DECIDE;
                r_peak_out <= w_peak_new;
              end
            end
          end
          DECIDE: begin
            if (r_peak > HI_V) begin
              r_up_dn  <= 1'b0;
              r_adjust <= 1'b1;
              r_state  <= ADJUST;
            end else if (r_peak < LO_V) begin
              r_up_dn  <= 1'b1;
              r_adjust <= 1'b1;
              r_state  <= ADJUST;
            end else begin
              r_locked <= 1'b1;
              r_state  <= LOCKED;
            end
          end
          ADJUST: begin
            r_state      <= SETTLE;
            r_settle_cnt <= '0;
          end
          SETTLE: begin
            // search_done only matters on the final settle cycle
            if (r_settle_cnt == SETTLE_LAST) begin
              if (search_done) begin
                r_locked <= 1'b1;
                r_state  <= LOCKED;
              end else begin
                r_state   <= MEASURE;
                r_peak    <= '0;
                r_win_cnt <= '0;
              end
            end else begin
              r_settle_cnt <= r_settle_cnt + 16'd1;
            end
          end
          LOCKED: begin
            r_locked <= 1'b1;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign adjust   = r_adjust;
  assign up_dn    = r_up_dn;
  assign locked   = r_locked;
  assign peak_out = r_peak_out;

endmodule
